// File: rtl/vid_cmd_sched.sv
// vid_cmd_sched: 8-deep command queue between the execution pipeline and the
// video unit. Commands are pushed from the write side and issued one at a
// time to the video side. Each issued command is held until it is acknowledged.
// Optional feature: define VID_CMD_VBLANK_GATE_EN to allow draining only while
// vblank is high. Without the macro the queue drains whenever it is non-empty.
module vid_cmd_sched (
    input  logic        clk,
    input  logic        reset,
    // write side
    input  logic        wr_valid,
    input  logic [1:0]  wr_type,
    input  logic [4:0]  wr_sel,
    input  logic [10:0] wr_a,
    input  logic [8:0]  wr_b,
    input  logic [2:0]  wr_flags,
    output logic        wr_ready,
    output logic        stall,
    // video timing
    input  logic        vblank,
    // video side
    output logic        vid_valid,
    output logic [1:0]  vid_type,
    output logic [4:0]  vid_sel,
    output logic [10:0] vid_a,
    output logic [8:0]  vid_b,
    output logic [2:0]  vid_flags,
    input  logic        vid_ack,
    // status
    output logic [3:0]  level,
    output logic        overflow
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    localparam logic [1:0] TYPE_RSVD = 2'b11;
    localparam logic [3:0] DEPTH     = 4'd8;

    // Entry layout: {type[29:28], sel[27:23], a[22:12], b[11:3], flags[2:0]}
    logic [29:0] mem_q [0:7];

    logic [2:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]  rd_ptr_q, rd_ptr_d;
    logic [3:0]  level_q, level_d;
    state_e      state_q;
    logic        vid_valid_q;
    logic [1:0]  vid_type_q;
    logic [4:0]  vid_sel_q;
    logic [10:0] vid_a_q;
    logic [8:0]  vid_b_q;
    logic [2:0]  vid_flags_q;
    logic        overflow_q;

    logic        gate_open;
    logic        push;
    logic        pop;
    logic        issue;
    logic [29:0] wr_entry;
    logic [29:0] head_entry;

`ifdef VID_CMD_VBLANK_GATE_EN
    assign gate_open = vblank;
`else
    // vblank is kept as a port for a uniform interface but plays no part here.
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign gate_open     = 1'b1;
`endif

    assign wr_ready   = (level_q < DEPTH);
    assign stall      = wr_valid & ~wr_ready;
    assign push       = wr_valid & wr_ready & (wr_type != TYPE_RSVD);
    assign pop        = (state_q == ST_ISSUE) & vid_ack;
    // Issue is only attempted when level is non-zero, so the head is always a written entry.
    assign issue      = (state_q == ST_IDLE) & (level_q != 4'd0) & gate_open;
    assign wr_entry   = {wr_type, wr_sel, wr_a, wr_b, wr_flags};
    assign head_entry = mem_q[rd_ptr_q];

    // Queue storage: plain write port, no reset so it can map to distributed/block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // Next pointer and occupancy; a push and a pop in one cycle leave level unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 3'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 3'd1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 4'd1;
            2'b01:   level_d = level_q - 4'd1;
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= 3'd0;
            rd_ptr_q <= 3'd0;
            level_q  <= 4'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Issue FSM: load the head into the output registers, hold it until acked.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            vid_valid_q <= 1'b0;
            vid_type_q  <= 2'd0;
            vid_sel_q   <= 5'd0;
            vid_a_q     <= 11'd0;
            vid_b_q     <= 9'd0;
            vid_flags_q <= 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        state_q     <= ST_ISSUE;
                        vid_valid_q <= 1'b1;
                        vid_type_q  <= head_entry[29:28];
                        vid_sel_q   <= head_entry[27:23];
                        vid_a_q     <= head_entry[22:12];
                        vid_b_q     <= head_entry[11:3];
                        vid_flags_q <= head_entry[2:0];
                    end
                end
                ST_ISSUE: begin
                    // Fields stay put until acked, even if the gate closes meanwhile.
                    if (vid_ack) begin
                        state_q     <= ST_IDLE;
                        vid_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    vid_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Sticky flag for reserved command types, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
        end else if (wr_valid && (wr_type == TYPE_RSVD)) begin
            overflow_q <= 1'b1;
        end
    end

    assign vid_valid = vid_valid_q;
    assign vid_type  = vid_type_q;
    assign vid_sel   = vid_sel_q;
    assign vid_a     = vid_a_q;
    assign vid_b     = vid_b_q;
    assign vid_flags = vid_flags_q;
    assign level     = level_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_vid_cmd_sched.sv
// Directed testbench for vid_cmd_sched. Expectations that depend on the
// optional VID_CMD_VBLANK_GATE_EN build are selected with the same macro.
module tb_vid_cmd_sched;

    logic        clk;
    logic        reset;
    logic        wr_valid;
    logic [1:0]  wr_type;
    logic [4:0]  wr_sel;
    logic [10:0] wr_a;
    logic [8:0]  wr_b;
    logic [2:0]  wr_flags;
    logic        wr_ready;
    logic        stall;
    logic        vblank;
    logic        vid_valid;
    logic [1:0]  vid_type;
    logic [4:0]  vid_sel;
    logic [10:0] vid_a;
    logic [8:0]  vid_b;
    logic [2:0]  vid_flags;
    logic        vid_ack;
    logic [3:0]  level;
    logic        overflow;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

`ifdef VID_CMD_VBLANK_GATE_EN
    localparam logic GATED = 1'b1;
`else
    localparam logic GATED = 1'b0;
`endif

    vid_cmd_sched dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_type(wr_type), .wr_sel(wr_sel), .wr_a(wr_a),
        .wr_b(wr_b), .wr_flags(wr_flags), .wr_ready(wr_ready), .stall(stall),
        .vblank(vblank),
        .vid_valid(vid_valid), .vid_type(vid_type), .vid_sel(vid_sel), .vid_a(vid_a),
        .vid_b(vid_b), .vid_flags(vid_flags), .vid_ack(vid_ack),
        .level(level), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected command set used by the fill/drain scenarios.
    function automatic logic [1:0] exp_type(input int i); return 2'(i % 3); endfunction
    function automatic logic [4:0] exp_sel(input int i); return 5'(i + 1); endfunction
    function automatic logic [10:0] exp_a(input int i); return 11'(100 * i + 7); endfunction
    function automatic logic [8:0] exp_b(input int i); return 9'(i * 11); endfunction
    function automatic logic [2:0] exp_flags(input int i); return 3'(i); endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive_cmd(input logic [1:0] t, input logic [4:0] s, input logic [10:0] a,
                             input logic [8:0] b, input logic [2:0] f);
        wr_valid = 1'b1; wr_type = t; wr_sel = s; wr_a = a; wr_b = b; wr_flags = f;
    endtask

    task automatic test_reset();
        reset = 1'b0; wr_valid = 1'b0; wr_type = 2'd0; wr_sel = 5'd0; wr_a = 11'd0;
        wr_b = 9'd0; wr_flags = 3'd0; vblank = 1'b0; vid_ack = 1'b0;
        #2;
        n_checks++; if (vid_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", vid_valid); else n_pass++;
        n_checks++; if (level !== 4'd0) $display("FAIL reset_level: got %0d want 0", level); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
        n_checks++; if ({vid_type, vid_sel, vid_a, vid_b, vid_flags} !== 30'd0) $display("FAIL reset_fields: got %h want 0", {vid_type, vid_sel, vid_a, vid_b, vid_flags}); else n_pass++;
        n_checks++; if (wr_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", wr_ready); else n_pass++;
        tick(); tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_issue();
        vblank = 1'b1;
        drive_cmd(2'b00, 5'd3, 11'd100, 9'd50, 3'b101);
        tick();
        wr_valid = 1'b0;
        n_checks++; if (level !== 4'd1) $display("FAIL single_level_push: got %0d want 1", level); else n_pass++;
        n_checks++; if (vid_valid !== 1'b0) $display("FAIL single_valid_early: got %b want 0", vid_valid); else n_pass++;
        tick();
        n_checks++; if (vid_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", vid_valid); else n_pass++;
        n_checks++; if ({vid_type, vid_sel, vid_a, vid_b, vid_flags} !== {2'b00, 5'd3, 11'd100, 9'd50, 3'b101})
            $display("FAIL single_fields: got type=%0d sel=%0d a=%0d b=%0d flags=%b want 0/3/100/50/101", vid_type, vid_sel, vid_a, vid_b, vid_flags); else n_pass++;
        vid_ack = 1'b1;
        tick();
        n_checks++; if (vid_valid !== 1'b0) $display("FAIL single_valid_after_ack: got %b want 0", vid_valid); else n_pass++;
        n_checks++; if (level !== 4'd0) $display("FAIL single_level_after_ack: got %0d want 0", level); else n_pass++;
        // Ack while idle with nothing queued must have no effect.
        tick();
        vid_ack = 1'b0;
        n_checks++; if (level !== 4'd0 || vid_valid !== 1'b0) $display("FAIL idle_ack: got level=%0d valid=%b want 0/0", level, vid_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        vblank = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_cmd(exp_type(i), exp_sel(i), exp_a(i), exp_b(i), exp_flags(i));
            tick();
        end
        // Ninth command offered into a full queue.
        drive_cmd(exp_type(8), exp_sel(8), exp_a(8), exp_b(8), exp_flags(8));
        #1;
        n_checks++; if (level !== 4'd8) $display("FAIL full_level: got %0d want 8", level); else n_pass++;
        n_checks++; if (wr_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", wr_ready); else n_pass++;
        n_checks++; if (stall !== 1'b1) $display("FAIL full_stall: got %b want 1", stall); else n_pass++;
        n_checks++; if (vid_valid !== !GATED) $display("FAIL full_vid_valid: got %b want %b", vid_valid, !GATED); else n_pass++;
        tick();
        wr_valid = 1'b0;
        n_checks++; if (level !== 4'd8) $display("FAIL full_level_after_9th: got %0d want 8", level); else n_pass++;
    endtask

    task automatic test_drain_order();
        int last;
        int wait_cnt;
        last = 0;
        vblank = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_cnt = 0;
            while (vid_valid !== 1'b1 && wait_cnt < 10) begin
                tick();
                wait_cnt++;
            end
            n_checks++; if (vid_valid !== 1'b1) $display("FAIL drain_timeout[%0d]: got valid=%b want 1", k, vid_valid); else n_pass++;
            n_checks++; if ({vid_type, vid_sel, vid_a, vid_b, vid_flags} !== {exp_type(k), exp_sel(k), exp_a(k), exp_b(k), exp_flags(k)})
                $display("FAIL drain_order[%0d]: got sel=%0d a=%0d want sel=%0d a=%0d", k, vid_sel, vid_a, exp_sel(k), exp_a(k)); else n_pass++;
            if (k > 0) begin
                n_checks++; if (cyc - last != 2) $display("FAIL drain_spacing[%0d]: got %0d want 2", k, cyc - last); else n_pass++;
            end
            last = cyc;
            vid_ack = 1'b1;
            tick();
            vid_ack = 1'b0;
            n_checks++; if (level !== 4'(7 - k)) $display("FAIL drain_level[%0d]: got %0d want %0d", k, level, 7 - k); else n_pass++;
        end
        tick();
        n_checks++; if (vid_valid !== 1'b0) $display("FAIL drain_empty_valid: got %b want 0", vid_valid); else n_pass++;
    endtask

    task automatic test_reserved();
        n_checks++; if (overflow !== 1'b0) $display("FAIL rsvd_pre_overflow: got %b want 0", overflow); else n_pass++;
        drive_cmd(2'b11, 5'd9, 11'd9, 9'd9, 3'd1);
        tick();
        wr_valid = 1'b0;
        n_checks++; if (level !== 4'd0) $display("FAIL rsvd_level: got %0d want 0", level); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL rsvd_overflow: got %b want 1", overflow); else n_pass++;
        tick(); tick(); tick();
        n_checks++; if (overflow !== 1'b1 || vid_valid !== 1'b0) $display("FAIL rsvd_sticky: got ovf=%b valid=%b want 1/0", overflow, vid_valid); else n_pass++;
    endtask

    task automatic test_gate_close();
        vblank = 1'b1;
        drive_cmd(2'b01, 5'd20, 11'd1500, 9'd300, 3'b011);
        tick();
        drive_cmd(2'b10, 5'd21, 11'd1600, 9'd301, 3'b110);
        tick();
        wr_valid = 1'b0;
        n_checks++; if (vid_valid !== 1'b1 || vid_sel !== 5'd20 || level !== 4'd2) $display("FAIL gate_issue: got valid=%b sel=%0d level=%0d want 1/20/2", vid_valid, vid_sel, level); else n_pass++;
        vblank = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_checks++; if ({vid_valid, vid_type, vid_sel, vid_a, vid_b, vid_flags} !== {1'b1, 2'b01, 5'd20, 11'd1500, 9'd300, 3'b011})
            $display("FAIL gate_hold: got valid=%b sel=%0d a=%0d b=%0d want 1/20/1500/300", vid_valid, vid_sel, vid_a, vid_b); else n_pass++;
        vid_ack = 1'b1;
        tick();
        vid_ack = 1'b0;
        n_checks++; if (vid_valid !== 1'b0 || level !== 4'd1) $display("FAIL gate_pop: got valid=%b level=%0d want 0/1", vid_valid, level); else n_pass++;
        tick(); tick(); tick();
        n_checks++; if (vid_valid !== !GATED) $display("FAIL gate_no_reissue: got %b want %b", vid_valid, !GATED); else n_pass++;
        vblank = 1'b1;
        tick();
        n_checks++; if (vid_valid !== 1'b1 || vid_sel !== 5'd21 || vid_a !== 11'd1600) $display("FAIL gate_reopen: got valid=%b sel=%0d a=%0d want 1/21/1600", vid_valid, vid_sel, vid_a); else n_pass++;
        vid_ack = 1'b1;
        tick();
        vid_ack = 1'b0;
        n_checks++; if (level !== 4'd0) $display("FAIL gate_final_level: got %0d want 0", level); else n_pass++;
    endtask

    task automatic test_reset_mid_issue();
        vblank = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_cmd(exp_type(i), exp_sel(i), exp_a(i), exp_b(i), exp_flags(i));
            tick();
        end
        wr_valid = 1'b0;
        n_checks++; if (vid_valid !== 1'b1 || level !== 4'd4) $display("FAIL rstmid_pre: got valid=%b level=%0d want 1/4", vid_valid, level); else n_pass++;
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if (vid_valid !== 1'b0 || level !== 4'd0) $display("FAIL rstmid_async: got valid=%b level=%0d want 0/0", vid_valid, level); else n_pass++;
        n_checks++; if (vid_sel !== 5'd0 || overflow !== 1'b0) $display("FAIL rstmid_clear: got sel=%0d ovf=%b want 0/0", vid_sel, overflow); else n_pass++;
        tick();
        reset = 1'b1;
        tick(); tick(); tick();
        n_checks++; if (vid_valid !== 1'b0 || level !== 4'd0) $display("FAIL rstmid_after: got valid=%b level=%0d want 0/0", vid_valid, level); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_issue();
        test_back_to_back();
        test_drain_order();
        test_reserved();
        test_gate_close();
        test_reset_mid_issue();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vid_cmd_sched.md
VID_CMD_SCHED -- requirements
Module: vid_cmd_sched

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 SHALL have port clk, input, 1: rising-edge clock.
REQ-003 SHALL have port reset, input, 1: async active-low reset.
REQ-004 SHALL have the write-side ports:
- wr_valid, input, 1: command offered by EXE.
- wr_type, input, 2: 00 sprite, 01 font, 10 background, 11 reserved.
- wr_sel, input, 5: sprite index.
- wr_a, input, 11: X coordinate or font address.
- wr_b, input, 9: Y coordinate or font data (low 4 bits).
- wr_flags, input, 3: {pos, attr, vis}.
REQ-005 SHALL have the pipeline-side outputs:
- wr_ready, output, 1: queue can accept.
- stall, output, 1: equals wr_valid AND NOT wr_ready.
REQ-006 SHALL have vblank, input, 1: video timing blanking window.
REQ-007 SHALL have the video-side ports:
- vid_valid, output, 1: command presented.
- vid_type, output, 2; vid_sel, output, 5; vid_a, output, 11; vid_b, output, 9; vid_flags, output, 3: command fields.
- vid_ack, input, 1: video unit consumed command.
REQ-008 SHALL have the status outputs:
- level, output, 4: entries queued, 0..8.
- overflow, output, 1: sticky flag, set when a reserved type is offered.

Function
REQ-009 SHALL buffer commands in an 8-entry FIFO of 30-bit entries {type, sel, a, b, flags}, with 3-bit wrapping read and write pointers.
REQ-010 SHALL drive wr_ready = (level < 8).
REQ-011 SHALL push on a rising edge when wr_valid && wr_ready && wr_type != 11.
REQ-012 SHALL drop a command with wr_type == 11 without pushing, and set overflow.
REQ-013 SHALL run an FSM with states IDLE and ISSUE; the reset state is IDLE.
REQ-014 IDLE -> ISSUE SHALL occur when level > 0 and the drain gate is open; on that edge the head entry is loaded into the vid_* registers and vid_valid is set to 1.
REQ-015 In ISSUE, the vid_* fields SHALL stay stable while vid_ack = 0.
REQ-016 ISSUE -> IDLE SHALL occur on an edge with vid_ack = 1; on that edge the entry is popped and vid_valid is cleared, so consecutive commands have at least one idle cycle between them.
REQ-017 Push and pop in the same cycle SHALL both take effect, leaving level unchanged; push is still gated by wr_ready as sampled at the start of that cycle.
REQ-018 If the gate closes (vblank falls) while in ISSUE, the issued command SHALL complete normally; no new issue occurs until the gate reopens.
REQ-019 Latency: a push into an empty queue with the gate open SHALL give vid_valid = 1 after the following edge, i.e. 1 cycle after the push edge.
REQ-020 Commands SHALL be issued in strict FIFO order; no reordering by type.
REQ-021 vid_ack received in IDLE SHALL be ignored.

Reset
REQ-022 While reset = 0, SHALL immediately (asynchronously) force: both pointers 0, level 0, state IDLE, vid_valid 0, all vid_* fields 0, overflow 0.
REQ-023 Reset asserted mid-ISSUE SHALL abandon the in-flight command and discard all queued entries, with no ack required.
REQ-024 FIFO storage contents need no reset; the design SHALL never read an unwritten entry.

Configuration
REQ-025 With macro VID_CMD_VBLANK_GATE_EN defined, the drain gate SHALL equal vblank.
REQ-026 Without VID_CMD_VBLANK_GATE_EN, the drain gate SHALL be constant 1; the vblank input stays present but is unused.

Verification
REQ-027 Reset, then push sprite {sel=3, a=100, b=50, flags=101} with vblank=1 -> vid_valid=1 one cycle after the push edge, vid_sel=3, vid_a=100, vid_b=50; ack -> level=0, vid_valid=0.
REQ-028 Push 9 commands back-to-back with vblank=0 and the gate macro on -> level=8, wr_ready=0, stall=1 on the 9th; vid_valid stays 0.
REQ-029 Full queue, raise vblank, ack every cycle vid_valid=1 -> 8 commands emerge in push order, each 2 cycles apart, level falls to 0.
REQ-030 Offer wr_type=11 -> level unchanged, overflow=1 until reset.
REQ-031 In ISSUE with vid_ack=0, drop vblank for 5 cycles -> fields hold; ack -> pop, no reissue until vblank=1.
REQ-032 Assert reset during ISSUE with level=4 -> vid_valid=0 and level=0 immediately; after release with no pushes, vid_valid stays 0.
